pwm_wave_sequencer: RTL and testbench
=====================================

Name: pwm_wave_sequencer

Overview:
- Upstream feeder for the oscilloscope's 8-bit PWM test-signal output stage (`PWM_module`). Drives its duty input `D`.
- A phase-accumulator waveform generator produces one duty sample per PWM period: DC, square, sawtooth or triangle, with amplitude and offset scaling.
- New duty values change only on PWM period boundaries. The PWM output never sees a mid-period duty change.
- Configuration arrives through a valid/ready handshake. It is double-buffered: shadow registers, committed at the next boundary.

Parameters:
- PWM_BITS, 8, PWM counter width; one period = 2^PWM_BITS clocks; duty/shape/amp/offset width.
- PHASE_W, 16, phase accumulator width; the top PWM_BITS bits index the waveform.

Ports:
- clk  in  1  system clock, same clock as `PWM_module`.
- rst  in  1  synchronous, active-high reset, same net as `PWM_module`.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accept; transfer when `cfg_valid` && `cfg_ready` at a rising edge.
- cfg_tune  in  PHASE_W  phase increment per PWM period.
- cfg_wave  in  2  0=DC (or sine, see option), 1=square, 2=sawtooth, 3=triangle.
- cfg_amp  in  PWM_BITS  amplitude.
- cfg_offset  in  PWM_BITS  DC offset.
- D  out  PWM_BITS  registered duty value to `PWM_module`.
- period_start  out  1  one-cycle pulse in the first cycle of each PWM period.

Behaviour:
- Reset:
  - `cnt`=0, `phase`=0.
  - Active and shadow config all zero.
  - FSM=IDLE.
  - `D`=0, `cfg_ready`=1, `period_start`=1 in the first cycle after `rst` drops, since `cnt`=0.
- Period counter `cnt`:
  - Free-running, PWM_BITS wide, wraps 2^PWM_BITS-1 -> 0.
  - Stays aligned with the PWM counter because both share `rst`.
  - `period_start` = (`cnt`==0), combinational from the register.
- Boundary edge: the edge where `cnt` goes from all-ones to 0. At that edge, simultaneously:
  - `D` <= `sat`(active_offset + ((`shape` * (active_amp+1)) >> PWM_BITS)), computed from the current `phase` and the current active config.
  - `phase` <= `phase` + active_tune, modulo 2^PHASE_W.
  - If FSM=PENDING: active <= shadow, FSM <= IDLE.
- Effect of a new config: it first affects `D` at the boundary after the commit, i.e. exactly one period of latency after commit.
- `D` is held constant for all 2^PWM_BITS clocks between boundaries.
- Shapes (`p` = top PWM_BITS bits of `phase`, MAX = 2^PWM_BITS-1):
  - DC: MAX.
  - Square: `p`[MSB] ? 0 : MAX.
  - Sawtooth: `p`.
  - Triangle: `p`[MSB]==0 ? 2*`p` : 2*(MAX-`p`), truncated to PWM_BITS.
- Arithmetic:
  - The product is 2*PWM_BITS wide, so amp=MAX passes `shape` unscaled.
  - The sum is PWM_BITS+1 wide; `sat` clamps it to MAX. No wrap.
- Handshake FSM:
  - IDLE: `cfg_ready`=1. On transfer, capture all cfg_* into shadow; go to PENDING.
  - PENDING: `cfg_ready`=0; `cfg_valid` is ignored. Leave only at a boundary (commit).
  - `cfg_ready` returns to 1 the cycle after the commit.
- Boundary conditions:
  - Transfer during the `cnt`==MAX cycle: shadow is loaded and FSM goes to PENDING at that edge. There is no same-edge commit; commit happens at the following boundary.
  - Two configs per period: impossible, because the second is stalled by `cfg_ready`=0.
  - `phase` is continuous across config changes and is cleared only by `rst`.
  - `rst` mid-period or while PENDING: the pending config is discarded and all reset values apply on the next edge.
  - `cfg_tune`=0: `D` is constant.
  - `phase` wrap is silent.

Optional Feature:
- Macro `PWM_WAVE_SINE_LUT_EN`.
- Defined:
  - `cfg_wave`=0 selects sine: a 64-entry quarter-wave ROM, addressed by `p`[5:0], mirrored and negated using `p`[7:6].
  - Output = 128 + `round`(127*`sin`(2π·`p`/256)), range 1..255.
  - Same `D` latency.
- Undefined: `cfg_wave`=0 is DC, and no ROM is synthesised.

Test Plan:
- Reset alignment:
  - Stimulus: release `rst`.
  - Required: `D`=0 and `cfg_ready`=1; `period_start` pulses at cycles 0, 256, 512 after release; `rst`=1 asserted mid-period returns `cnt`, `D` and `phase` to 0 on the next edge.
- Sawtooth ramp:
  - Stimulus: accept {`cfg_tune`=0x0100, `cfg_wave`=2, `cfg_amp`=255, `cfg_offset`=0} at cycle 5.
  - Required: `cfg_ready`=0 until boundary 1, then 1. `D`=0 at boundaries 1 and 2; `D`=1 at boundary 3; `D`=k-2 at boundary k; 255 -> 0 wrap at boundary 258.
- Saturation:
  - Stimulus: DC, `cfg_amp`=200, `cfg_offset`=100.
  - Required: `D`=255, not 44. With `cfg_offset`=50: `D`=250.
- Square/triangle:
  - Stimulus: `cfg_tune`=0x4000, square, amp 128.
  - Required: `D` sequence 128, 128, 0, 0, repeating.
  - Same `cfg_tune` with triangle, amp 255: 0, 128, 254, 126.
- Handshake edge:
  - Stimulus: `cfg_valid` held high from the `cnt`==255 cycle with two different configs back-to-back.
  - Required: the first is accepted at that edge; the second is stalled until the cycle after the next boundary; `D` never changes mid-period (checked every cycle).
- Sine (`PWM_WAVE_SINE_LUT_EN` defined):
  - Stimulus: `cfg_wave`=0, `cfg_tune`=0x4000, amp 255, offset 0.
  - Required: `D` sequence 128, 255, 128, 1.

Source files
------------

// File: rtl/pwm_wave_sequencer_if.sv
// pwm_wave_sequencer_if: valid/ready configuration channel for the PWM waveform sequencer
interface pwm_wave_sequencer_if #(
   parameter int PWM_BITS = 8,
   parameter int PHASE_W  = 16
);
   logic                cfg_valid;
   logic                cfg_ready;
   logic [PHASE_W-1:0]  cfg_tune;
   logic [1:0]          cfg_wave;
   logic [PWM_BITS-1:0] cfg_amp;
   logic [PWM_BITS-1:0] cfg_offset;
   modport master (output cfg_valid, cfg_tune, cfg_wave, cfg_amp, cfg_offset, input cfg_ready);
   modport slave  (input cfg_valid, cfg_tune, cfg_wave, cfg_amp, cfg_offset, output cfg_ready);
endinterface

// File: rtl/pwm_wave_sequencer.sv
// pwm_wave_sequencer: phase-accumulator duty generator, one sample per PWM period, double-buffered config.
// Define PWM_WAVE_SINE_LUT_EN to turn wave 0 from DC into a quarter-wave-ROM sine.
module pwm_wave_sequencer #(
   parameter int PWM_BITS = 8,
   parameter int PHASE_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   pwm_wave_sequencer_if.slave cfg,
   output logic [PWM_BITS-1:0] D,
   output logic                period_start
);
   localparam logic [PWM_BITS-1:0] MAX = '1;
   typedef struct packed {
      logic [PHASE_W-1:0]  tune;
      logic [1:0]          wave;
      logic [PWM_BITS-1:0] amp;
      logic [PWM_BITS-1:0] offset;
   } cfg_t;
   typedef enum logic {IDLE, PENDING} state_t;
   state_t              state, state_n;
   cfg_t                act, sh;
   logic [PWM_BITS-1:0] cnt, p, tri_w, wave0, shape, scaled;
   logic [PHASE_W-1:0]  phase;
   logic [PWM_BITS:0]   amp1, sum;
   logic [2*PWM_BITS-1:0] prod;
   logic                bnd, xfer;
   assign bnd          = cnt == MAX;
   assign period_start = cnt == '0;
   assign p            = phase[PHASE_W-1 -: PWM_BITS];
   assign xfer         = cfg.cfg_valid && cfg.cfg_ready;
`ifdef PWM_WAVE_SINE_LUT_EN
   // entry i holds round(127*sin(2*pi*(i+1)/256)); sin(0) is handled outside the ROM
   localparam int SIN_Q [64] = '{
        3,   6,   9,  12,  16,  19,  22,  25,  28,  31,  34,  37,  40,  43,  46,  49,
       51,  54,  57,  60,  63,  65,  68,  71,  73,  76,  78,  81,  83,  85,  88,  90,
       92,  94,  96,  98, 100, 102, 104, 106, 107, 109, 111, 112, 113, 115, 116, 117,
      118, 120, 121, 122, 122, 123, 124, 125, 125, 126, 126, 126, 127, 127, 127, 127};
   localparam logic [PWM_BITS-1:0] HALF = {1'b1, {(PWM_BITS-1){1'b0}}};
   logic [5:0]          j;
   logic [PWM_BITS-1:0] mag;
   assign j     = p[5:0];
   assign mag   = PWM_BITS'(p[PWM_BITS-2] ? SIN_Q[~j] : (j == '0 ? 0 : SIN_Q[j - 6'd1]));
   assign wave0 = p[PWM_BITS-1] ? HALF - mag : HALF + mag;
`else
   assign wave0 = MAX;
`endif
   assign tri_w  = p[PWM_BITS-1] ? {~p[PWM_BITS-2:0], 1'b0} : {p[PWM_BITS-2:0], 1'b0};
   assign shape  = act.wave == 2'd1 ? (p[PWM_BITS-1] ? '0 : MAX) :
                   act.wave == 2'd2 ? p :
                   act.wave == 2'd3 ? tri_w : wave0;
   // amp+1 makes amp=MAX a unity gain after the shift
   assign amp1   = {1'b0, act.amp} + (PWM_BITS+1)'(1);
   assign prod   = {{PWM_BITS{1'b0}}, shape} * {{(PWM_BITS-1){1'b0}}, amp1};
   assign scaled = PWM_BITS'(prod >> PWM_BITS);
   assign sum    = {1'b0, act.offset} + {1'b0, scaled};
   always_comb begin
      cfg.cfg_ready = state == IDLE;
      state_n       = state == IDLE ? (cfg.cfg_valid ? PENDING : IDLE) : (bnd ? IDLE : PENDING);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         phase <= '0;
         D     <= '0;
         state <= IDLE;
         act   <= '0;
         sh    <= '0;
      end else begin
         cnt   <= cnt + PWM_BITS'(1);
         state <= state_n;
         if (xfer) sh <= {cfg.cfg_tune, cfg.cfg_wave, cfg.cfg_amp, cfg.cfg_offset};
         if (bnd) begin
            D     <= sum[PWM_BITS] ? MAX : sum[PWM_BITS-1:0];
            phase <= phase + act.tune;
            if (state == PENDING) act <= sh;
         end
      end
   end
endmodule

// File: tb/tb_pwm_wave_sequencer.sv
// tb_pwm_wave_sequencer: directed vector table plus multi-cycle handshake/reset sequences.
module tb_pwm_wave_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] D;
   logic       period_start;
   int         total = 0;
   int         bad = 0;
   pwm_wave_sequencer_if #(.PWM_BITS(8), .PHASE_W(16)) cfg ();
   pwm_wave_sequencer #(.PWM_BITS(8), .PHASE_W(16)) dut (
      .clk(clk), .rst(rst), .cfg(cfg), .D(D), .period_start(period_start));
   always #5 clk = ~clk;
   typedef struct packed {
      logic [15:0]     tune;
      logic [1:0]      wave;
      logic [7:0]      amp;
      logic [7:0]      off;
      logic [3:0][7:0] exp;
   } vec_t;
   vec_t vecs[$];
   function automatic vec_t mk(logic [15:0] tune, logic [1:0] wave, logic [7:0] amp, logic [7:0] off,
                               logic [7:0] e0, logic [7:0] e1, logic [7:0] e2, logic [7:0] e3);
      vec_t v;
      v.tune = tune;
      v.wave = wave;
      v.amp  = amp;
      v.off  = off;
      v.exp  = {e3, e2, e1, e0};
      return v;
   endfunction
   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cfg.cfg_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic wait_bnd(output int cyc);
      logic [7:0] prev;
      bit held;
      prev = D;
      held = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (!period_start && D !== prev) held = 1'b0;
      end while (!period_start && cyc < 300);
      chk("hold", int'(held), 1);
      chk("boundary", int'(period_start), 1);
   endtask
   task automatic send(input logic [15:0] tune, input logic [1:0] wave, input logic [7:0] amp, input logic [7:0] off);
      int n = 0;
      @(negedge clk);
      cfg.cfg_tune   = tune;
      cfg.cfg_wave   = wave;
      cfg.cfg_amp    = amp;
      cfg.cfg_offset = off;
      cfg.cfg_valid  = 1'b1;
      while (!cfg.cfg_ready && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("accept", int'(cfg.cfg_ready), 1);
      @(posedge clk);
      #1 cfg.cfg_valid = 1'b0;
   endtask
   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int c, n;
      cfg.cfg_valid  = 1'b0;
      cfg.cfg_tune   = '0;
      cfg.cfg_wave   = '0;
      cfg.cfg_amp    = '0;
      cfg.cfg_offset = '0;
      vecs.push_back(mk(16'h0000, 2'd1, 8'd200, 8'd100, 255, 255, 255, 255));
      vecs.push_back(mk(16'h0000, 2'd1, 8'd200, 8'd50,  250, 250, 250, 250));
      vecs.push_back(mk(16'h4000, 2'd1, 8'd128, 8'd0,   128, 128, 0,   0));
      vecs.push_back(mk(16'h4000, 2'd3, 8'd255, 8'd0,   0,   128, 254, 126));
      vecs.push_back(mk(16'h0000, 2'd2, 8'd255, 8'd10,  10,  10,  10,  10));
      vecs.push_back(mk(16'h0100, 2'd2, 8'd255, 8'd0,   0,   1,   2,   3));
      vecs.push_back(mk(16'h4000, 2'd2, 8'd255, 8'd250, 250, 255, 255, 255));
`ifdef PWM_WAVE_SINE_LUT_EN
      vecs.push_back(mk(16'h4000, 2'd0, 8'd255, 8'd0,   128, 255, 128, 1));
`else
      vecs.push_back(mk(16'h0000, 2'd0, 8'd200, 8'd100, 255, 255, 255, 255));
      vecs.push_back(mk(16'h0000, 2'd0, 8'd200, 8'd50,  250, 250, 250, 250));
`endif
      do_reset();
      chk("rst_d", int'(D), 0);
      chk("rst_ready", int'(cfg.cfg_ready), 1);
      chk("rst_ps", int'(period_start), 1);
      wait_bnd(c);
      chk("period_256", c, 256);
      wait_bnd(c);
      chk("period_512", c, 256);
      foreach (vecs[i]) begin
         do_reset();
         repeat (3) @(negedge clk);
         send(vecs[i].tune, vecs[i].wave, vecs[i].amp, vecs[i].off);
         @(negedge clk);
         chk($sformatf("v%0d_ready_low", i), int'(cfg.cfg_ready), 0);
         wait_bnd(c);
         chk($sformatf("v%0d_ready_b1", i), int'(cfg.cfg_ready), 1);
         chk($sformatf("v%0d_d_b1", i), int'(D), 0);
         for (int k = 0; k < 4; k++) begin
            wait_bnd(c);
            chk($sformatf("v%0d_d_b%0d", i, k + 2), int'(D), int'(vecs[i].exp[k]));
         end
      end
      // back-to-back offers starting in the cnt==255 cycle
      do_reset();
      repeat (255) @(negedge clk);
      cfg.cfg_tune = 16'h0100; cfg.cfg_wave = 2'd2; cfg.cfg_amp = 8'd255; cfg.cfg_offset = 8'd0;
      cfg.cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg.cfg_tune = 16'h4000; cfg.cfg_wave = 2'd1; cfg.cfg_amp = 8'd128; cfg.cfg_offset = 8'd0;
      @(negedge clk);
      chk("hs_ps_b1", int'(period_start), 1);
      chk("hs_ready_b1", int'(cfg.cfg_ready), 0);
      n = 0;
      while (!cfg.cfg_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("hs_stall_len", n, 256);
      chk("hs_ready_at_bnd", int'(period_start), 1);
      chk("hs_d_b2", int'(D), 0);
      @(posedge clk);
      #1 cfg.cfg_valid = 1'b0;
      @(negedge clk);
      chk("hs_ready_low2", int'(cfg.cfg_ready), 0);
      wait_bnd(c);
      chk("hs_d_b3", int'(D), 0);
      chk("hs_ready_b3", int'(cfg.cfg_ready), 1);
      wait_bnd(c);
      chk("hs_d_b4", int'(D), 128);
      wait_bnd(c);
      chk("hs_d_b5", int'(D), 128);
      wait_bnd(c);
      chk("hs_d_b6", int'(D), 0);
      // reset mid-period while a config is pending
      do_reset();
      send(16'h4000, 2'd1, 8'd255, 8'd0);
      wait_bnd(c);
      wait_bnd(c);
      chk("mr_d_run", int'(D), 255);
      repeat (100) @(negedge clk);
      send(16'h4000, 2'd2, 8'd255, 8'd7);
      @(negedge clk);
      chk("mr_pending", int'(cfg.cfg_ready), 0);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_d", int'(D), 0);
      chk("mr_ps", int'(period_start), 1);
      chk("mr_ready", int'(cfg.cfg_ready), 1);
      rst = 1'b0;
      wait_bnd(c);
      chk("mr_d_b1", int'(D), 0);
      wait_bnd(c);
      chk("mr_discarded", int'(D), 0);
      send(16'h0100, 2'd2, 8'd255, 8'd0);
      wait_bnd(c);
      wait_bnd(c);
      chk("mr_phase_cleared", int'(D), 0);
      // long sawtooth ramp through the 8-bit wrap
      do_reset();
      repeat (4) @(negedge clk);
      send(16'h0100, 2'd2, 8'd255, 8'd0);
      @(negedge clk);
      chk("saw_ready_low", int'(cfg.cfg_ready), 0);
      for (int k = 1; k <= 258; k++) begin
         wait_bnd(c);
         if (k == 1) chk("saw_ready_b1", int'(cfg.cfg_ready), 1);
         chk($sformatf("saw_b%0d", k), int'(D), k < 2 ? 0 : (k - 2) % 256);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
